vx_dispatch_batch: RTL and testbench
====================================

// Module: vx_dispatch_batch
// PURPOSE
//  Parametrised issue-to-execute dispatcher between the operand-collect stage and NUM_EX execute units.
//  Routes each decoded instruction plus its GPR operands to the unit selected by ex_type.
//  When NUM_LANES < NUM_THREADS, splits the warp into lane batches, skipping batches with an empty tmask slice.
//  Each unit has its own elastic output buffer of depth OUT_DEPTH.
// PARAMETERS
//  NUM_EX      5   number of execute-unit channels (ch0 = ALU/default)
//  NUM_THREADS 4   threads per warp
//  NUM_LANES   4   threads per emitted packet; must divide NUM_THREADS
//  HDRW        64  packed per-instruction header bits (uuid, wid, PC, op_type, op_mod, imm, rd, wb, ...)
//  DATAW       96  per-thread operand bits (rs1|rs2|rs3)
//  OUT_DEPTH   2   per-channel output buffer entries; must be >= 1
// PORTS
//  clk          in   1                    clock
//  reset        in   1                    asynchronous, active-low reset
//  in_valid     in   1                    dispatch request valid
//  in_ready     out  1                    request consumed; high only when the last batch is accepted
//  in_ex_type   in   EX_BITS              target channel; values >= NUM_EX route to ch0
//  in_tmask     in   NUM_THREADS          thread mask
//  in_hdr       in   HDRW                 instruction header
//  in_data      in   NUM_THREADS*DATAW    operands, thread-major
//  out_valid    out  NUM_EX               per-channel valid
//  out_ready    in   NUM_EX               per-channel ready
//  out_hdr      out  NUM_EX*HDRW          header, repeated on every batch
//  out_tmask    out  NUM_EX*NUM_LANES     tmask slice for this batch
//  out_data     out  NUM_EX*NUM_LANES*DATAW  operand slice
//  out_pid      out  NUM_EX*PID_BITS      batch index
//  out_sop      out  NUM_EX               first packet of the instruction
//  out_eop      out  NUM_EX               last packet of the instruction
//  out_tid      out  NUM_EX*TID_BITS      global index of the lowest set bit of in_tmask (0 if the mask is empty)
// BEHAVIOUR
//  - Reset (reset==0, async): FSM=IDLE, pid=0, all buffers empty.
//    Consequently out_valid=0, in_ready=0, and all other outputs read 0.
//  - BATCHES = NUM_THREADS/NUM_LANES. When BATCHES==1 the FSM degenerates, pid/sop/eop are constant 0/1/1,
//    and in_ready = buffer-not-full of the selected channel.
//  - IDLE: on in_valid, pid_cur = first batch with a non-zero slice.
//    If the whole tmask is 0, emit one packet with pid=0 and sop=eop=1.
//  - A packet is pushed when in_valid && selected buffer not full.
//    - sop=1 on the first pushed packet.
//    - eop=1 when no later non-zero batch exists.
//  - After a push without eop: move to BATCH, and pid advances to the next non-zero batch (masked priority encode).
//    Empty batches cost no cycles.
//  - Push with eop: in_ready=1 in the same cycle (combinational from buffer-full), FSM returns to IDLE.
//  - Input fields must stay stable while in_valid && !in_ready.
//    Deasserting in_valid mid-batch is illegal; the bench asserts against it.
//  - Output buffers
//    - Each is a registered FIFO; out_* are driven from flops.
//    - Latency from input push to out_valid is 1 cycle; throughput is 1 packet/cycle/channel.
//    - If the buffer is full, a simultaneous push and pop is allowed (no bubble).
//    - Full = OUT_DEPTH entries. Occupancy counter is clog2(OUT_DEPTH+1) bits; no wrap beyond full or below empty.
//  - Backpressure on one channel never stalls already-buffered packets on other channels.
//    A new instruction to a different channel waits until the current instruction's eop push.
//  - Ordering: packets within a channel leave in push order; pid is strictly increasing within an instruction.
//  - Reset asserted mid-batch: the partial instruction is dropped and all buffered packets are discarded.
//  - PID_BITS = max(1, clog2(BATCHES)); TID_BITS = max(1, clog2(NUM_THREADS)); EX_BITS = max(1, clog2(NUM_EX)).
// STRUCTURE
//  - Package vx_dispatch_pkg
//    - localparams BATCHES, PID_BITS, TID_BITS, EX_BITS.
//    - Typedef dispatch_pkt_t {hdr, tmask, data, pid, sop, eop, tid}.
//    - Function next_batch(mask, pid).
//  - Sub-module vx_dispatch_lane_buf: one per channel, generate loop.
//    Parametrised FIFO of dispatch_pkt_t: valid/ready in, valid/ready out, depth OUT_DEPTH.
//  - Top level holds the FSM, pid register, batch slicing, tid encoder and channel demux.
// TESTING
//  1. NUM_LANES=4, NUM_THREADS=4, ex_type=2, tmask=4'b1010, out_ready=all 1
//     -> ch2 out_valid next cycle, sop=eop=1, tid=1, in_ready high in the accept cycle.
//  2. NUM_THREADS=8, NUM_LANES=2, tmask=8'b1100_0011
//     -> 2 packets on the target channel: pid=0 (sop=1), pid=3 (eop=1). Batches 1 and 2 skipped; in_ready on cycle 2 only.
//  3. tmask=0, ex_type=1
//     -> single packet on ch1, pid=0, sop=eop=1, tmask slice 0, tid=0.
//  4. OUT_DEPTH=2, ch0 out_ready=0, 3 back-to-back ch0 instructions
//     -> 2 accepted, the 3rd stalls with in_ready=0.
//     Then out_ready=1 -> the 3rd is accepted in the same cycle as the first pop; order preserved.
//  5. ch3 stalled and full; a ch0 instruction arrives
//     -> accepted and delivered, ch3 packets unchanged. ex_type=7 (NUM_EX=5) -> routed to ch0.
//  6. reset pulsed low asynchronously mid-batch (pid=1 of 4)
//     -> out_valid=0 and in_ready=0 immediately. After release the FSM is IDLE and the next instruction starts at sop.

Source files
------------

// File: rtl/vx_dispatch_pkg.sv
// Shared definitions for the issue-to-execute dispatcher.
//  - Default configuration and derived widths (BATCHES, PID_BITS, TID_BITS, EX_BITS).
//  - bits_min1(): width of an index into n items, never less than 1.
//  - next_batch(): masked priority encode of the batch-occupancy vector.
// The packet struct lives in the top module because its field widths follow
// the module parameters, which a package cannot see.
package vx_dispatch_pkg;

    localparam int DEF_NUM_EX      = 5;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NUM_LANES   = 4;

    // Upper bound on batches per warp handled by next_batch().
    localparam int MAX_BATCHES = 32;

    function automatic int bits_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BATCHES  = DEF_NUM_THREADS / DEF_NUM_LANES;
    localparam int PID_BITS = bits_min1(BATCHES);
    localparam int TID_BITS = bits_min1(DEF_NUM_THREADS);
    localparam int EX_BITS  = bits_min1(DEF_NUM_EX);

    // Lowest index >= pid whose bit is set in mask; MAX_BATCHES when none.
    function automatic int next_batch(input logic [MAX_BATCHES-1:0] mask, input int pid);
        int r;
        r = MAX_BATCHES;
        for (int i = MAX_BATCHES - 1; i >= 0; i--) begin
            if (i >= pid && mask[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/vx_dispatch_lane_buf.sv
// Per-channel elastic output buffer: a registered FIFO of DEPTH packets.
// Ports: clk, reset (async, active-low), in_valid/in_ready/in_pkt (push side),
//        out_valid/out_ready/out_pkt (pop side, driven from storage flops).
// When full, a push is still accepted in a cycle where the head is popped.
module vx_dispatch_lane_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pkt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_pkt
);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [PTRW-1:0] rd_q, wr_q;
    logic [CNTW-1:0] cnt_q;
    logic            push, pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign out_valid = (cnt_q != '0);
    assign in_ready  = (cnt_q != CNTW'(DEPTH)) || out_ready;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_pkt   = mem[rd_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_q] <= in_pkt;
                wr_q      <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
            if (push && !pop)      cnt_q <= cnt_q + CNTW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNTW'(1);
        end
    end

endmodule

// File: rtl/vx_dispatch_batch.sv
// Issue-to-execute dispatcher. Routes an instruction and its operands to the
// execute channel chosen by in_ex_type (out-of-range -> ch0), splitting the
// warp into NUM_LANES-wide batches and skipping batches with an empty mask.
// Ports: clk, reset (async, active-low);
//        in_valid/in_ready, in_ex_type, in_tmask, in_hdr, in_data (request);
//        per channel: out_valid/out_ready, out_hdr, out_tmask, out_data,
//        out_pid, out_sop, out_eop, out_tid (flattened, channel-major).
module vx_dispatch_batch
    import vx_dispatch_pkg::*;
#(
    parameter int NUM_EX      = DEF_NUM_EX,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int HDRW        = 64,
    parameter int DATAW       = 96,
    parameter int OUT_DEPTH   = 2,
    localparam int NB   = NUM_THREADS / NUM_LANES,
    localparam int PIDW = bits_min1(NB),
    localparam int TIDW = bits_min1(NUM_THREADS),
    localparam int EXW  = bits_min1(NUM_EX)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EXW-1:0]                   in_ex_type,
    input  logic [NUM_THREADS-1:0]           in_tmask,
    input  logic [HDRW-1:0]                  in_hdr,
    input  logic [NUM_THREADS*DATAW-1:0]     in_data,
    output logic [NUM_EX-1:0]                out_valid,
    input  logic [NUM_EX-1:0]                out_ready,
    output logic [NUM_EX*HDRW-1:0]           out_hdr,
    output logic [NUM_EX*NUM_LANES-1:0]      out_tmask,
    output logic [NUM_EX*NUM_LANES*DATAW-1:0] out_data,
    output logic [NUM_EX*PIDW-1:0]           out_pid,
    output logic [NUM_EX-1:0]                out_sop,
    output logic [NUM_EX-1:0]                out_eop,
    output logic [NUM_EX*TIDW-1:0]           out_tid
);
    typedef struct packed {
        logic [HDRW-1:0]            hdr;
        logic [NUM_LANES-1:0]       tmask;
        logic [NUM_LANES*DATAW-1:0] data;
        logic [PIDW-1:0]            pid;
        logic                       sop;
        logic                       eop;
        logic [TIDW-1:0]            tid;
    } dispatch_pkt_t;

    typedef enum logic {IDLE, BATCH} state_t;

    state_t                      state_q, state_d;
    logic [PIDW-1:0]             pid_q, pid_d, pid_cur;
    logic [MAX_BATCHES-1:0]      nz;
    int                          first_i, next_i;
    logic                        eop;
    logic [TIDW-1:0]             tid;
    logic [EXW-1:0]              sel;
    logic [NUM_EX-1:0]           buf_ready;
    logic                        push;
    dispatch_pkt_t               pkt_in;
    dispatch_pkt_t [NUM_EX-1:0]  pkt_out;

    // Batch slicing: occupancy vector, current batch, and whether a later
    // occupied batch exists. From IDLE the first occupied batch is used
    // directly so leading empty batches cost no cycle.
    always_comb begin
        nz = '0;
        for (int b = 0; b < NB; b++) nz[b] = |in_tmask[b*NUM_LANES +: NUM_LANES];
        first_i = next_batch(nz, 0);
        if (state_q == IDLE) pid_cur = (first_i < NB) ? PIDW'(first_i) : '0;
        else                 pid_cur = pid_q;
        next_i = next_batch(nz, int'(pid_cur) + 1);
        eop    = (next_i >= NB);

        tid = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (in_tmask[t]) tid = TIDW'(t);
        end

        sel = (int'(in_ex_type) < NUM_EX) ? in_ex_type : '0;
    end

    // Gating with reset keeps in_ready low while reset is held.
    assign push     = reset && in_valid && buf_ready[sel];
    assign in_ready = push && eop;

    always_comb begin
        pkt_in.hdr   = in_hdr;
        pkt_in.tmask = in_tmask[int'(pid_cur)*NUM_LANES +: NUM_LANES];
        pkt_in.data  = in_data[int'(pid_cur)*NUM_LANES*DATAW +: NUM_LANES*DATAW];
        pkt_in.pid   = pid_cur;
        pkt_in.sop   = (state_q == IDLE);
        pkt_in.eop   = eop;
        pkt_in.tid   = tid;
    end

    always_comb begin
        state_d = state_q;
        pid_d   = pid_q;
        if (push) begin
            if (eop) begin
                state_d = IDLE;
                pid_d   = '0;
            end else begin
                state_d = BATCH;
                pid_d   = PIDW'(next_i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            pid_q   <= pid_d;
        end
    end

    for (genvar c = 0; c < NUM_EX; c++) begin : g_ch
        vx_dispatch_lane_buf #(
            .W     ($bits(dispatch_pkt_t)),
            .DEPTH (OUT_DEPTH)
        ) u_buf (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (push && (sel == EXW'(c))),
            .in_ready  (buf_ready[c]),
            .in_pkt    (pkt_in),
            .out_valid (out_valid[c]),
            .out_ready (out_ready[c]),
            .out_pkt   (pkt_out[c])
        );

        assign out_hdr[c*HDRW +: HDRW]                       = pkt_out[c].hdr;
        assign out_tmask[c*NUM_LANES +: NUM_LANES]           = pkt_out[c].tmask;
        assign out_data[c*NUM_LANES*DATAW +: NUM_LANES*DATAW] = pkt_out[c].data;
        assign out_pid[c*PIDW +: PIDW]                       = pkt_out[c].pid;
        assign out_sop[c]                                    = pkt_out[c].sop;
        assign out_eop[c]                                    = pkt_out[c].eop;
        assign out_tid[c*TIDW +: TIDW]                       = pkt_out[c].tid;
    end

endmodule

// File: tb/tb_vx_dispatch_batch.sv
module tb_vx_dispatch_batch;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_EX=5, 4 threads, 4 lanes (single batch)
    logic          a_in_valid, a_in_ready;
    logic [2:0]    a_in_ex_type;
    logic [3:0]    a_in_tmask;
    logic [63:0]   a_in_hdr;
    logic [383:0]  a_in_data;
    logic [4:0]    a_out_valid, a_out_ready;
    logic [319:0]  a_out_hdr;
    logic [19:0]   a_out_tmask;
    logic [1919:0] a_out_data;
    logic [4:0]    a_out_pid, a_out_sop, a_out_eop;
    logic [9:0]    a_out_tid;

    // Instance B: NUM_EX=2, 8 threads, 2 lanes (4 batches)
    logic          b_in_valid, b_in_ready;
    logic [0:0]    b_in_ex_type;
    logic [7:0]    b_in_tmask;
    logic [15:0]   b_in_hdr;
    logic [63:0]   b_in_data;
    logic [1:0]    b_out_valid, b_out_ready;
    logic [31:0]   b_out_hdr;
    logic [3:0]    b_out_tmask;
    logic [31:0]   b_out_data;
    logic [3:0]    b_out_pid;
    logic [1:0]    b_out_sop, b_out_eop;
    logic [5:0]    b_out_tid;

    vx_dispatch_batch #(
        .NUM_EX(5), .NUM_THREADS(4), .NUM_LANES(4), .HDRW(64), .DATAW(96), .OUT_DEPTH(2)
    ) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ex_type(a_in_ex_type),
        .in_tmask(a_in_tmask), .in_hdr(a_in_hdr), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_hdr(a_out_hdr),
        .out_tmask(a_out_tmask), .out_data(a_out_data), .out_pid(a_out_pid),
        .out_sop(a_out_sop), .out_eop(a_out_eop), .out_tid(a_out_tid)
    );

    vx_dispatch_batch #(
        .NUM_EX(2), .NUM_THREADS(8), .NUM_LANES(2), .HDRW(16), .DATAW(8), .OUT_DEPTH(2)
    ) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ex_type(b_in_ex_type),
        .in_tmask(b_in_tmask), .in_hdr(b_in_hdr), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_hdr(b_out_hdr),
        .out_tmask(b_out_tmask), .out_data(b_out_data), .out_pid(b_out_pid),
        .out_sop(b_out_sop), .out_eop(b_out_eop), .out_tid(b_out_tid)
    );

    typedef struct packed {
        logic [63:0] hdr; logic [3:0] tmask; logic [383:0] data;
        logic [0:0] pid; logic sop; logic eop; logic [1:0] tid;
    } pa_t;

    typedef struct packed {
        logic [15:0] hdr; logic [1:0] tmask; logic [15:0] data;
        logic [1:0] pid; logic sop; logic eop; logic [2:0] tid;
    } pb_t;

    pa_t qa[5][$];
    pb_t qb[2][$];
    int  total = 0;
    int  bad = 0;
    bit  acc_a, acc_b;
    int  pops_a[5];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int low_bit(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [383:0] rnd384();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference model: one packet per non-empty batch, one packet if mask is empty.
    task automatic exp_a(input int ex, input logic [3:0] tm, input logic [63:0] h, input logic [383:0] d);
        pa_t p;
        int  ch;
        ch      = (ex < 5) ? ex : 0;
        p.hdr   = h;
        p.tmask = tm;
        p.data  = d;
        p.pid   = 1'b0;
        p.sop   = 1'b1;
        p.eop   = 1'b1;
        p.tid   = 2'(low_bit({4'b0, tm}));
        qa[ch].push_back(p);
    endtask

    task automatic exp_b(input int ex, input logic [7:0] tm, input logic [15:0] h, input logic [63:0] d,
                         output int npkt);
        int  list[$];
        pb_t p;
        for (int b = 0; b < 4; b++) if (tm[b*2 +: 2] != 2'b00) list.push_back(b);
        if (list.size() == 0) list.push_back(0);
        for (int k = 0; k < list.size(); k++) begin
            p.hdr   = h;
            p.tmask = tm[list[k]*2 +: 2];
            p.data  = d[list[k]*16 +: 16];
            p.pid   = 2'(list[k]);
            p.sop   = (k == 0);
            p.eop   = (k == list.size() - 1);
            p.tid   = 3'(low_bit(tm));
            qb[ex].push_back(p);
        end
        npkt = list.size();
    endtask

    // Pop/compare every handshake seen at the sampling edge.
    task automatic sb();
        pa_t oa, ea;
        pb_t ob, eb;
        for (int c = 0; c < 5; c++) begin
            if (a_out_valid[c] && a_out_ready[c]) begin
                pops_a[c]++;
                oa.hdr = a_out_hdr[c*64 +: 64];   oa.tmask = a_out_tmask[c*4 +: 4];
                oa.data = a_out_data[c*384 +: 384]; oa.pid = a_out_pid[c];
                oa.sop = a_out_sop[c]; oa.eop = a_out_eop[c]; oa.tid = a_out_tid[c*2 +: 2];
                chk($sformatf("a_sb_has_entry_ch%0d", c), 512'(qa[c].size() != 0), 512'(1));
                if (qa[c].size() != 0) begin
                    ea = qa[c].pop_front();
                    chk($sformatf("a_pkt_ch%0d", c), 512'(oa), 512'(ea));
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            if (b_out_valid[c] && b_out_ready[c]) begin
                ob.hdr = b_out_hdr[c*16 +: 16];   ob.tmask = b_out_tmask[c*2 +: 2];
                ob.data = b_out_data[c*16 +: 16]; ob.pid = b_out_pid[c*2 +: 2];
                ob.sop = b_out_sop[c]; ob.eop = b_out_eop[c]; ob.tid = b_out_tid[c*3 +: 3];
                chk($sformatf("b_sb_has_entry_ch%0d", c), 512'(qb[c].size() != 0), 512'(1));
                if (qb[c].size() != 0) begin
                    eb = qb[c].pop_front();
                    chk($sformatf("b_pkt_ch%0d", c), 512'(ob), 512'(eb));
                end
            end
        end
    endtask

    // One cycle: sample at negedge, then return 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        acc_a = a_in_ready;
        acc_b = b_in_ready;
        sb();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int ex, input logic [3:0] tm, input logic [63:0] h, input logic [383:0] d,
                          output int n);
        exp_a(ex, tm, h, d);
        a_in_valid = 1'b1; a_in_ex_type = 3'(ex); a_in_tmask = tm; a_in_hdr = h; a_in_data = d;
        n = 0;
        do begin step(); n++; end while (!acc_a && n < 40);
        a_in_valid = 1'b0;
        chk("a_accept", 512'(acc_a), 512'(1));
    endtask

    task automatic send_b(input int ex, input logic [7:0] tm, input logic [15:0] h, input logic [63:0] d,
                          output int n, output int npkt);
        exp_b(ex, tm, h, d, npkt);
        b_in_valid = 1'b1; b_in_ex_type = 1'(ex); b_in_tmask = tm; b_in_hdr = h; b_in_data = d;
        n = 0;
        do begin step(); n++; end while (!acc_b && n < 40);
        b_in_valid = 1'b0;
        chk("b_accept", 512'(acc_b), 512'(1));
    endtask

    initial begin
        int n, np;
        logic [63:0] h31;
        logic [7:0]  tm;

        a_in_valid = 0; a_in_ex_type = 0; a_in_tmask = 0; a_in_hdr = 0; a_in_data = 0;
        a_out_ready = 5'b11111;
        b_in_valid = 0; b_in_ex_type = 0; b_in_tmask = 0; b_in_hdr = 0; b_in_data = 0;
        b_out_ready = 2'b11;
        for (int i = 0; i < 5; i++) pops_a[i] = 0;

        // Reset state, with a request present to show in_ready stays low
        #1;
        a_in_valid = 1'b1; a_in_tmask = 4'b0001;
        #1;
        chk("rst_a_in_ready", 512'(a_in_ready), 512'(0));
        chk("rst_a_out_valid", 512'(a_out_valid), 512'(0));
        chk("rst_a_out_hdr", 512'(a_out_hdr), 512'(0));
        chk("rst_a_out_misc", 512'({|a_out_data, a_out_tmask, a_out_pid, a_out_sop, a_out_eop, a_out_tid}), 512'(0));
        chk("rst_b_out", 512'({b_out_valid, b_in_ready, b_out_hdr, b_out_pid, b_out_sop, b_out_eop, b_out_tid}), 512'(0));
        a_in_valid = 1'b0; a_in_tmask = 4'b0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // 1: single batch to ch2
        send_a(2, 4'b1010, rnd64(), rnd384(), n);
        chk("t1_cycles", 512'(n), 512'(1));
        chk("t1_valid", 512'(a_out_valid), 512'(5'b00100));
        chk("t1_sop_eop", 512'({a_out_sop[2], a_out_eop[2]}), 512'(2'b11));
        chk("t1_tid", 512'(a_out_tid[5:4]), 512'(1));
        step();

        // 3: empty mask to ch1
        send_a(1, 4'b0000, rnd64(), rnd384(), n);
        chk("t3_valid", 512'(a_out_valid), 512'(5'b00010));
        chk("t3_tmask_tid", 512'({a_out_tmask[7:4], a_out_tid[3:2]}), 512'(0));
        step();

        // 4: ch0 backpressure, 3rd instruction stalls until the first pop
        a_out_ready = 5'b11110;
        send_a(0, 4'b0001, rnd64(), rnd384(), n);
        send_a(0, 4'b0110, rnd64(), rnd384(), n);
        exp_a(0, 4'b1000, 64'h3333, rnd384());
        a_in_valid = 1'b1; a_in_ex_type = 3'd0; a_in_tmask = 4'b1000; a_in_hdr = 64'h3333;
        a_in_data = qa[0][2].data;
        step();
        chk("t4_stall0", 512'(acc_a), 512'(0));
        step();
        chk("t4_stall1", 512'(acc_a), 512'(0));
        chk("t4_ch0_valid", 512'(a_out_valid[0]), 512'(1));
        a_out_ready = 5'b11111;
        pops_a[0] = 0;
        step();
        chk("t4_accept", 512'(acc_a), 512'(1));
        chk("t4_pop_same_cycle", 512'(pops_a[0]), 512'(1));
        a_in_valid = 1'b0;
        repeat (4) step();

        // 5: ch3 stalled and full, ch0 traffic still flows
        a_out_ready = 5'b10111;
        h31 = rnd64();
        send_a(3, 4'b0100, h31, rnd384(), n);
        send_a(3, 4'b0010, rnd64(), rnd384(), n);
        send_a(0, 4'b1111, rnd64(), rnd384(), n);
        chk("t5_ch0_cycles", 512'(n), 512'(1));
        chk("t5_ch3_hold", 512'(a_out_valid[3]), 512'(1));
        chk("t5_ch3_hdr", 512'(a_out_hdr[3*64 +: 64]), 512'(h31));
        send_a(7, 4'b1100, rnd64(), rnd384(), n);
        chk("t5_route7", 512'(a_out_valid & 5'b00111), 512'(5'b00001));
        step();
        chk("t5_ch3_hdr_after", 512'(a_out_hdr[3*64 +: 64]), 512'(h31));
        a_out_ready = 5'b11111;
        repeat (4) step();

        // 2: sparse mask on 4-batch instance, batches 1 and 2 skipped
        send_b(1, 8'b1100_0011, 16'hBEEF, {$urandom, $urandom}, n, np);
        chk("t2_cycles", 512'(n), 512'(2));
        chk("t2_npkt_model", 512'(n), 512'(np));
        repeat (3) step();

        // Assorted masks: accept latency equals number of non-empty batches
        for (int k = 0; k < 8; k++) begin
            tm = (k == 0) ? 8'h00 : 8'($urandom);
            send_b(int'($urandom_range(0, 1)), tm, 16'($urandom), {$urandom, $urandom}, n, np);
            chk($sformatf("b_cycles_%0d", k), 512'(n), 512'(np));
        end
        repeat (4) step();

        // 6: async reset mid-batch (pid=1 of 4)
        b_in_valid = 1'b1; b_in_ex_type = 1'b0; b_in_tmask = 8'hFF; b_in_hdr = 16'h1234;
        b_in_data = {$urandom, $urandom};
        step();
        chk("t6_pre_valid", 512'(b_out_valid), 512'(2'b01));
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_valid", 512'(b_out_valid), 512'(0));
        chk("t6_rst_ready", 512'(b_in_ready), 512'(0));
        b_in_valid = 1'b0;
        step();
        reset = 1'b1;
        send_b(0, 8'hFF, 16'h5678, {$urandom, $urandom}, n, np);
        chk("t6_restart_cycles", 512'(n), 512'(4));
        repeat (5) step();

        chk("sb_drained", 512'(qa[0].size() + qa[1].size() + qa[2].size() + qa[3].size() + qa[4].size()
                               + qb[0].size() + qb[1].size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
